// File: rtl/sym_vn_rank_lut.sv
`default_nettype none
// ============================================================================
//  Module   : sym_vn_rank_lut
//  Purpose  : Symmetric variable-node information-bottleneck lookup table for
//             the 3-bit quantised partial VNU. An address bus packs each
//             message pair {y0 magnitude, y1} into a 5-bit page address. A
//             32 x 3 table rank is read asynchronously through two
//             independent ports (A and B) and written through one
//             synchronous port.
//  Ports    : write_clk       - sole clock, rising edge
//             rstn            - synchronous active-low reset, clears the table
//             y0_in_A/B [1:0] - y0 magnitude bits, sign-transposed upstream
//             y1_in_A/B [2:0] - y1 message, sign-conditioned upstream
//             page_addr_A/B   - 5-bit page address {y0, y1}
//             lut_data0/1     - table content at page_addr_A / page_addr_B
//             lut_in_bank0    - write data
//             page_write_addr - write address
//             we              - write enable, active-high
//  Revision : 1.0 - initial release
// ============================================================================
module sym_vn_rank_lut (
  input  logic       write_clk,
  input  logic       rstn,
  input  logic [1:0] y0_in_A,
  input  logic [2:0] y1_in_A,
  input  logic [1:0] y0_in_B,
  input  logic [2:0] y1_in_B,
  output logic [4:0] page_addr_A,
  output logic [4:0] page_addr_B,
  output logic [2:0] lut_data0,
  output logic [2:0] lut_data1,
  input  logic [2:0] lut_in_bank0,
  input  logic [4:0] page_write_addr,
  input  logic       we
);

  localparam int c_DEPTH = 32;

  logic [2:0] r_mem [c_DEPTH];

  // y0 occupies the upper two bits; every 5-bit value is a legal page.
  assign page_addr_A = {y0_in_A, y1_in_A};
  assign page_addr_B = {y0_in_B, y1_in_B};

  // Reset has priority: a write presented during reset is discarded.
  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= 3'b000;
      end
    end else if (we) begin
      r_mem[page_write_addr] <= lut_in_bank0;
    end
  end

  // Asynchronous reads with no write bypass: a same-address write shows up
  // only after the committing edge.
  assign lut_data0 = r_mem[page_addr_A];
  assign lut_data1 = r_mem[page_addr_B];

endmodule
`default_nettype wire

// File: tb/tb_sym_vn_rank_lut.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sym_vn_rank_lut
//  Purpose  : Self-checking bench for sym_vn_rank_lut: address-mapping vector
//             table, directed corner sequences and randomized traffic against
//             an array-based reference of the table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sym_vn_rank_lut;

  logic       write_clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] y0_in_A = '0;
  logic [2:0] y1_in_A = '0;
  logic [1:0] y0_in_B = '0;
  logic [2:0] y1_in_B = '0;
  logic [4:0] page_addr_A;
  logic [4:0] page_addr_B;
  logic [2:0] lut_data0;
  logic [2:0] lut_data1;
  logic [2:0] lut_in_bank0 = '0;
  logic [4:0] page_write_addr = '0;
  logic       we = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference contents of the table.
  logic [2:0] model [32];

  sym_vn_rank_lut dut (
    .write_clk       (write_clk),
    .rstn            (rstn),
    .y0_in_A         (y0_in_A),
    .y1_in_A         (y1_in_A),
    .y0_in_B         (y0_in_B),
    .y1_in_B         (y1_in_B),
    .page_addr_A     (page_addr_A),
    .page_addr_B     (page_addr_B),
    .lut_data0       (lut_data0),
    .lut_data1       (lut_data1),
    .lut_in_bank0    (lut_in_bank0),
    .page_write_addr (page_write_addr),
    .we              (we)
  );

  always #5 write_clk = ~write_clk;

  typedef struct {
    logic [1:0] y0a;
    logic [2:0] y1a;
    logic [1:0] y0b;
    logic [2:0] y1b;
    logic [4:0] exp_a;
    logic [4:0] exp_b;
  } addr_vec_t;

  addr_vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Point both read ports at the given page addresses and let them settle.
  task automatic set_reads(input logic [4:0] a, input logic [4:0] b);
    y0_in_A = a[4:3];
    y1_in_A = a[2:0];
    y0_in_B = b[4:3];
    y1_in_B = b[2:0];
    #1;
  endtask

  // One clock edge with the given controls; the model follows the same rules.
  task automatic cycle(input logic r, input logic w, input logic [4:0] addr,
                       input logic [2:0] data);
    rstn            = r;
    we              = w;
    page_write_addr = addr;
    lut_in_bank0    = data;
    @(posedge write_clk);
    if (!r) begin
      foreach (model[i]) model[i] = 3'd0;
    end else if (w) begin
      model[addr] = data;
    end
    #1;
    rstn = 1'b1;
    we   = 1'b0;
  endtask

  task automatic chk_entry(input string name, input logic [4:0] a, input int exp);
    set_reads(a, a);
    chk({name, "_p0"}, int'(lut_data0), exp);
    chk({name, "_p1"}, int'(lut_data1), exp);
  endtask

  initial begin
    foreach (model[i]) model[i] = 3'd0;

    // Reset state
    cycle(1'b0, 1'b0, 5'd0, 3'd0);
    chk_entry("reset_init_a0", 5'd0, 0);
    chk_entry("reset_init_a31", 5'd31, 0);

    // Reset clear after filling with 3'b101
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 5'(i), 3'b101);
    chk_entry("filled_a17", 5'd17, 5);
    cycle(1'b0, 1'b0, 5'd0, 3'd0);
    chk_entry("reset_clr_a0", 5'd0, 0);
    chk_entry("reset_clr_a17", 5'd17, 0);
    chk_entry("reset_clr_a31", 5'd31, 0);

    // Address mapping vectors
    vecs[0] = '{2'b10, 3'b011, 2'b01, 3'b111, 5'd19, 5'd15};
    vecs[1] = '{2'b00, 3'b000, 2'b11, 3'b111, 5'd0,  5'd31};
    vecs[2] = '{2'b11, 3'b000, 2'b00, 3'b111, 5'd24, 5'd7};
    vecs[3] = '{2'b01, 3'b001, 2'b10, 3'b110, 5'd9,  5'd22};
    vecs[4] = '{2'b11, 3'b101, 2'b11, 3'b101, 5'd29, 5'd29};
    vecs[5] = '{2'b00, 3'b100, 2'b01, 3'b000, 5'd4,  5'd8};
    for (int v = 0; v < 6; v++) begin
      y0_in_A = vecs[v].y0a;
      y1_in_A = vecs[v].y1a;
      y0_in_B = vecs[v].y0b;
      y1_in_B = vecs[v].y1b;
      #1;
      chk($sformatf("addr_map_A[%0d]", v), int'(page_addr_A), int'(vecs[v].exp_a));
      chk($sformatf("addr_map_B[%0d]", v), int'(page_addr_B), int'(vecs[v].exp_b));
    end

    // Write mem[i] = i % 8, then sweep every address pair
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 5'(i), 3'(i % 8));
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        set_reads(5'(a), 5'(b));
        chk($sformatf("sweep_d0[%0d,%0d]", a, b), int'(lut_data0), a % 8);
        chk($sformatf("sweep_d1[%0d,%0d]", a, b), int'(lut_data1), b % 8);
      end
    end

    // Read-during-write: mem[5]=2, then write 6 to addr 5
    cycle(1'b1, 1'b1, 5'd5, 3'd2);
    set_reads(5'd5, 5'd5);
    rstn = 1'b1; we = 1'b1; page_write_addr = 5'd5; lut_in_bank0 = 3'd6;
    #1;
    chk("rdw_before_edge", int'(lut_data0), 2);
    @(posedge write_clk);
    model[5] = 3'd6;
    #1;
    we = 1'b0;
    chk("rdw_after_edge", int'(lut_data0), 6);

    // Write disable, then reset priority over we
    cycle(1'b1, 1'b1, 5'd9, 3'd3);
    cycle(1'b1, 1'b0, 5'd9, 3'd7);
    chk_entry("we0_hold_a9", 5'd9, 3);
    cycle(1'b0, 1'b1, 5'd9, 3'd5);
    chk_entry("rst_prio_a9", 5'd9, 0);

    // Boundary writes on consecutive edges over a known background
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 5'(i), 3'(i % 8));
    rstn = 1'b1; we = 1'b1; page_write_addr = 5'd0; lut_in_bank0 = 3'b111;
    @(posedge write_clk);
    #1;
    page_write_addr = 5'd31; lut_in_bank0 = 3'b001;
    @(posedge write_clk);
    #1;
    we = 1'b0;
    model[0] = 3'd7; model[31] = 3'd1;
    chk_entry("bound_a0", 5'd0, 7);
    chk_entry("bound_a31", 5'd31, 1);
    for (int i = 1; i < 31; i++) begin
      set_reads(5'(i), 5'(31 - i));
      chk($sformatf("bound_other_d0[%0d]", i), int'(lut_data0), i % 8);
      chk($sformatf("bound_other_d1[%0d]", i), int'(lut_data1), (31 - i) % 8);
    end

    // Randomized traffic against the reference array
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ra, rb, wa;
      logic [2:0] wd;
      logic       w, r;
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      wd = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
      set_reads(ra, rb);
      chk($sformatf("rand_pre_d0[%0d]", n), int'(lut_data0), int'(model[ra]));
      chk($sformatf("rand_pre_d1[%0d]", n), int'(lut_data1), int'(model[rb]));
      cycle(r, w, wa, wd);
      chk($sformatf("rand_post_d0[%0d]", n), int'(lut_data0), int'(model[ra]));
      chk($sformatf("rand_post_d1[%0d]", n), int'(lut_data1), int'(model[rb]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
